// File: rtl/imem_arbiter.sv
// Purpose: two-port round-robin arbiter and sequencer for a 1-cycle-latency single-port instruction SRAM.
// Latency: a request accepted in cycle N returns its response in N+1 (read data or a zero write ack).
// Backpressure: a stalled response parks in a per-port one-entry buffer; that port is not granted until it drains.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   mK_req_{valid,ready,we,addr,wdata}  per-port request channel (K = 0 fetch, 1 loader/debug)
//   mK_rsp_{valid,ready,rdata}          per-port response channel
//   mem_{en,we,addr,wdata}_o, mem_rdata_i   SRAM interface
// Optional: define IMEM_ARB_ADDR_CHK_EN to reject addresses beyond the SRAM (adds mK_rsp_err_o).

module imem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] SRAM_DEPTH = 32'h0000_4000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_valid_i,
  output logic                  m0_req_ready_o,
  input  logic                  m0_req_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata_i,
  output logic                  m0_rsp_valid_o,
  input  logic                  m0_rsp_ready_i,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata_o,
`ifdef IMEM_ARB_ADDR_CHK_EN
  output logic                  m0_rsp_err_o,
`endif
  input  logic                  m1_req_valid_i,
  output logic                  m1_req_ready_o,
  input  logic                  m1_req_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata_i,
  output logic                  m1_rsp_valid_o,
  input  logic                  m1_rsp_ready_i,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata_o,
`ifdef IMEM_ARB_ADDR_CHK_EN
  output logic                  m1_rsp_err_o,
`endif
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  // Per-port views of the request/response channels, indexed by port number.
  logic [1:0]            req_valid, req_we, rsp_ready;
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];

  assign req_valid    = {m1_req_valid_i, m0_req_valid_i};
  assign req_we       = {m1_req_we_i, m0_req_we_i};
  assign rsp_ready    = {m1_rsp_ready_i, m0_rsp_ready_i};
  assign req_addr[0]  = m0_req_addr_i;
  assign req_addr[1]  = m1_req_addr_i;
  assign req_wdata[0] = m0_req_wdata_i;
  assign req_wdata[1] = m1_req_wdata_i;

  // State: inflight = issued last cycle, buf = response parked under backpressure.
  logic [1:0]            inflight_q, inflight_d;
  logic [1:0]            inflight_we_q, inflight_we_d;
  logic [1:0]            buf_valid_q, buf_valid_d;
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [DATA_WIDTH-1:0] buf_data_d [2];
  logic                  rr_last_q, rr_last_d;

  logic [1:0]            eligible, grant, rsp_valid;
  logic                  win;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] live_rdata [2];
  logic [DATA_WIDTH-1:0] rsp_rdata  [2];

`ifdef IMEM_ARB_ADDR_CHK_EN
  localparam logic [63:0] MAX_ADDR = 64'(SRAM_DEPTH) * 64'd4 - 64'd4;
  logic [1:0] inflight_err_q, inflight_err_d;
  logic [1:0] buf_err_q, buf_err_d;
  logic [1:0] live_err, rsp_err;

  assign in_range = (64'(req_addr[win]) <= MAX_ADDR);
`else
  assign in_range = 1'b1;
`endif

  always_comb begin
    // A port may issue only if its previous response is gone by the next edge,
    // so the single-entry buffer can never be asked to hold two responses.
    for (int k = 0; k < 2; k++) begin
      eligible[k] = !rst_i && req_valid[k] && !buf_valid_q[k] &&
                    (!inflight_q[k] || rsp_ready[k]);
    end
    // On a tie the port that did not win last time goes first.
    grant[0] = eligible[0] && (!eligible[1] || rr_last_q);
    grant[1] = eligible[1] && (!eligible[0] || !rr_last_q);
    win      = grant[1];

    mem_en_o    = (|grant) && in_range;
    mem_we_o    = mem_en_o ? req_we[win] : 1'b0;
    mem_addr_o  = mem_en_o ? req_addr[win] : '0;
    mem_wdata_o = mem_en_o ? req_wdata[win] : '0;

    inflight_d    = grant;
    inflight_we_d = grant & req_we;
    rr_last_d     = (|grant) ? grant[1] : rr_last_q;
`ifdef IMEM_ARB_ADDR_CHK_EN
    inflight_err_d = in_range ? 2'b00 : grant;
    buf_err_d      = buf_err_q;
`endif

    for (int k = 0; k < 2; k++) begin
      live_rdata[k] = inflight_we_q[k] ? '0 : mem_rdata_i;
`ifdef IMEM_ARB_ADDR_CHK_EN
      live_err[k] = inflight_err_q[k];
      if (inflight_err_q[k]) live_rdata[k] = DATA_WIDTH'(32'hDEAD_BEEF);
      rsp_err[k] = buf_valid_q[k] ? buf_err_q[k] : (inflight_q[k] & live_err[k]);
`endif
      rsp_valid[k] = inflight_q[k] | buf_valid_q[k];
      // Idle ports present zero rather than whatever the SRAM last returned.
      rsp_rdata[k] = buf_valid_q[k] ? buf_data_q[k] :
                     (inflight_q[k] ? live_rdata[k] : '0);

      buf_valid_d[k] = buf_valid_q[k];
      buf_data_d[k]  = buf_data_q[k];
      if (inflight_q[k] && !rsp_ready[k]) begin
        // SRAM output is only valid for one cycle: capture it now.
        buf_valid_d[k] = 1'b1;
        buf_data_d[k]  = live_rdata[k];
`ifdef IMEM_ARB_ADDR_CHK_EN
        buf_err_d[k]   = live_err[k];
`endif
      end else if (buf_valid_q[k] && rsp_ready[k]) begin
        buf_valid_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q    <= '0;
      inflight_we_q <= '0;
      buf_valid_q   <= '0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      rr_last_q     <= 1'b1;
`ifdef IMEM_ARB_ADDR_CHK_EN
      inflight_err_q <= '0;
      buf_err_q      <= '0;
`endif
    end else begin
      inflight_q    <= inflight_d;
      inflight_we_q <= inflight_we_d;
      buf_valid_q   <= buf_valid_d;
      buf_data_q    <= buf_data_d;
      rr_last_q     <= rr_last_d;
`ifdef IMEM_ARB_ADDR_CHK_EN
      inflight_err_q <= inflight_err_d;
      buf_err_q      <= buf_err_d;
`endif
    end
  end

  assign m0_req_ready_o = grant[0];
  assign m1_req_ready_o = grant[1];
  assign m0_rsp_valid_o = rsp_valid[0];
  assign m1_rsp_valid_o = rsp_valid[1];
  assign m0_rsp_rdata_o = rsp_rdata[0];
  assign m1_rsp_rdata_o = rsp_rdata[1];
`ifdef IMEM_ARB_ADDR_CHK_EN
  assign m0_rsp_err_o = rsp_err[0];
  assign m1_rsp_err_o = rsp_err[1];
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Purpose: randomized plus directed bench for imem_arbiter against a transaction-level reference.
// Latency: the model expects each accepted request's response one cycle later.
// Backpressure: the model tracks at most one pending response per port and its age.

module tb_imem_arbiter;

  localparam logic [31:0] MAX_ADDR = 32'h0000_FFFC;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i;
  logic [1:0]  rv, rwe, rr;
  logic [31:0] ra [2];
  logic [31:0] rwd [2];

  logic        m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid;
  logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
`ifdef IMEM_ARB_ADDR_CHK_EN
  logic        m0_rsp_err, m1_rsp_err;
`endif

  imem_arbiter dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .m0_req_valid_i (rv[0]),
    .m0_req_ready_o (m0_req_ready),
    .m0_req_we_i    (rwe[0]),
    .m0_req_addr_i  (ra[0]),
    .m0_req_wdata_i (rwd[0]),
    .m0_rsp_valid_o (m0_rsp_valid),
    .m0_rsp_ready_i (rr[0]),
    .m0_rsp_rdata_o (m0_rsp_rdata),
`ifdef IMEM_ARB_ADDR_CHK_EN
    .m0_rsp_err_o   (m0_rsp_err),
`endif
    .m1_req_valid_i (rv[1]),
    .m1_req_ready_o (m1_req_ready),
    .m1_req_we_i    (rwe[1]),
    .m1_req_addr_i  (ra[1]),
    .m1_req_wdata_i (rwd[1]),
    .m1_rsp_valid_o (m1_rsp_valid),
    .m1_rsp_ready_i (rr[1]),
    .m1_rsp_rdata_o (m1_rsp_rdata),
`ifdef IMEM_ARB_ADDR_CHK_EN
    .m1_rsp_err_o   (m1_rsp_err),
`endif
    .mem_en_o       (mem_en),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata)
  );

  // SRAM: one-cycle read latency, word indexed by the byte address.
  logic [31:0] sram [0:16383];
  always @(posedge clk_i) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr[15:2]] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr[15:2]];
    end
  end

  // Reference: memory contents plus one pending response per port with its issue cycle.
  logic [31:0] ref_mem [0:16383];
  logic [1:0]  pvld, perr, acc;
  logic [31:0] pdata [2];
  int          pcyc [2];
  int          cyc;
  logic        last_port;
  logic        post_rst;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Compare the current cycle, then advance the reference across the clock edge.
  task automatic step();
    logic [1:0]  el, win, rdy_obs, vld_obs, err_obs;
    logic [31:0] rd_obs [2];
    logic        oor, exp_en;
    int          w;
    #3;
    rdy_obs   = {m1_req_ready, m0_req_ready};
    vld_obs   = {m1_rsp_valid, m0_rsp_valid};
    rd_obs[0] = m0_rsp_rdata;
    rd_obs[1] = m1_rsp_rdata;
`ifdef IMEM_ARB_ADDR_CHK_EN
    err_obs   = {m1_rsp_err, m0_rsp_err};
`else
    err_obs   = 2'b00;
`endif
    for (int k = 0; k < 2; k++)
      el[k] = !rst_i && rv[k] && (!pvld[k] || (pcyc[k] == cyc - 1 && rr[k]));
    win = 2'b00;
    if (el == 2'b11) win[last_port ? 0 : 1] = 1'b1;
    else             win = el;
    w = win[1] ? 1 : 0;
    oor = 1'b0;
`ifdef IMEM_ARB_ADDR_CHK_EN
    oor = ra[w] > MAX_ADDR;
`endif
    exp_en = (|win) && !oor;

    check("req_ready", 64'(rdy_obs), 64'(win));
    check("mem_en", 64'(mem_en), 64'(exp_en));
    if (exp_en) begin
      check("mem_we", 64'(mem_we), 64'(rwe[w]));
      check("mem_addr", 64'(mem_addr), 64'(ra[w]));
      check("mem_wdata", 64'(mem_wdata), 64'(rwd[w]));
    end else begin
      check("mem_idle", 64'({mem_we, mem_addr}), 64'd0);
      check("mem_idle_wdata", 64'(mem_wdata), 64'd0);
    end
    for (int k = 0; k < 2; k++) begin
      check(k ? "rsp_valid1" : "rsp_valid0", 64'(vld_obs[k]), 64'(pvld[k]));
      if (pvld[k]) begin
        check(k ? "rsp_rdata1" : "rsp_rdata0", 64'(rd_obs[k]), 64'(pdata[k]));
        check(k ? "rsp_err1" : "rsp_err0", 64'(err_obs[k]), 64'(perr[k]));
      end else if (post_rst) begin
        check(k ? "rst_rdata1" : "rst_rdata0", 64'(rd_obs[k]), 64'd0);
      end
    end

    post_rst = rst_i;
    if (rst_i) begin
      pvld      = 2'b00;
      last_port = 1'b1;
      acc       = 2'b00;
    end else begin
      for (int k = 0; k < 2; k++)
        if (pvld[k] && rr[k]) pvld[k] = 1'b0;
      if (|win) begin
        pvld[w]  = 1'b1;
        pcyc[w]  = cyc;
        perr[w]  = oor;
        pdata[w] = oor ? 32'hDEAD_BEEF : (rwe[w] ? 32'd0 : ref_mem[ra[w][15:2]]);
        if (rwe[w] && !oor) ref_mem[ra[w][15:2]] = rwd[w];
        last_port = win[1];
      end
      acc = win;
    end
    @(posedge clk_i);
    cyc++;
    #1;
  endtask

  task automatic req(input int k, input logic v, input logic we,
                     input logic [31:0] a, input logic [31:0] d);
    rv[k]  = v;
    rwe[k] = we;
    ra[k]  = a;
    rwd[k] = d;
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < 2; k++) begin
      // A waiting request must stay unchanged until it is accepted.
      if (!(rv[k] && !acc[k])) begin
        rv[k]  = ($urandom_range(0, 3) != 0);
        rwe[k] = ($urandom_range(0, 2) == 0);
        ra[k]  = ($urandom_range(0, 39) == 0) ? 32'h0001_0000 : (32'($urandom_range(0, 63)) << 2);
        rwd[k] = $urandom;
      end
      rr[k] = ($urandom_range(0, 3) != 0);
    end
    rst_i = ($urandom_range(0, 149) == 0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      sram[i]    = 32'd0;
      ref_mem[i] = 32'd0;
    end
    mem_rdata = 32'd0;
    rst_i = 1'b1;
    rv = 2'b00; rwe = 2'b00; rr = 2'b11;
    for (int k = 0; k < 2; k++) begin ra[k] = 32'd0; rwd[k] = 32'd0; pdata[k] = 32'd0; pcyc[k] = 0; end
    pvld = 2'b00; perr = 2'b00; acc = 2'b00;
    cyc = 0; last_port = 1'b1; post_rst = 1'b1;
    @(posedge clk_i); #1;

    // Reset held with requests pending: nothing may be accepted.
    req(0, 1'b1, 1'b0, 32'h0, 32'h0);
    step(); step();
    rst_i = 1'b0;

    // Contention: grants alternate starting with port 0.
    req(0, 1'b1, 1'b0, 32'h100, 32'h0);
    req(1, 1'b1, 1'b0, 32'h104, 32'h0);
    repeat (8) step();
    req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Single read after a loader write.
    req(1, 1'b1, 1'b1, 32'h10, 32'h1234_5678); step();
    req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    req(0, 1'b1, 1'b0, 32'h10, 32'h0); step();
    req(0, 1'b0, 1'b0, 32'h0, 32'h0); step();

    // Backpressure on port 0 while port 1 keeps reading.
    req(1, 1'b1, 1'b1, 32'h20, 32'hAAAA_5555); step();
    req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    rr[0] = 1'b0;
    req(0, 1'b1, 1'b0, 32'h20, 32'h0); step();
    req(1, 1'b1, 1'b0, 32'h10, 32'h0);
    repeat (3) step();
    rr[0] = 1'b1;
    repeat (3) step();
    req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Write ack then read-back.
    req(1, 1'b1, 1'b1, 32'h40, 32'hCAFE_F00D); step();
    req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    req(0, 1'b1, 1'b0, 32'h40, 32'h0); step();
    req(0, 1'b0, 1'b0, 32'h0, 32'h0); step();

    // Reset with port 0 inflight and port 1 buffered.
    req(1, 1'b1, 1'b0, 32'h10, 32'h0); step();
    req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    rr[1] = 1'b0;
    req(0, 1'b1, 1'b0, 32'h20, 32'h0); step();
    req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_i = 1'b1; step();
    rst_i = 1'b0; rr = 2'b11;
    req(0, 1'b1, 1'b0, 32'h40, 32'h0);
    req(1, 1'b1, 1'b0, 32'h20, 32'h0);
    repeat (3) step();
    req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Address beyond the SRAM.
    req(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0); step();
    req(0, 1'b0, 1'b0, 32'h0, 32'h0); step();

    repeat (3000) begin
      rand_inputs();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
